// File: rtl/exers_pkg.sv
// exers_pkg: shared constants and the entry record for the exers_rs
// reservation station. The widths here match the station's default
// parameters; the entry struct is sized from them.
package exers_pkg;

  localparam int EXERS_DEPTH   = 8;
  localparam int EXERS_DATA_W  = 32;
  localparam int EXERS_ROBID_W = 8;
  localparam int EXERS_RD_W    = 6;
  localparam int EXERS_OP_W    = 5;

  // Opcode MSB selects the execute class
  localparam int   EXERS_CLASS_BIT = EXERS_OP_W - 1;
  localparam logic CLASS_SCALU     = 1'b0;
  localparam logic CLASS_MCALU     = 1'b1;

  // One reservation station slot. While an operand is not ready its low
  // ROBID bits hold the producer tag instead of a value.
  typedef struct packed {
    logic                     valid;
    logic [EXERS_OP_W-1:0]    op;
    logic [EXERS_ROBID_W-1:0] robid;
    logic [EXERS_RD_W-1:0]    rd;
    logic [EXERS_DATA_W-1:0]  op1;
    logic                     op1_ready;
    logic [EXERS_DATA_W-1:0]  op2;
    logic                     op2_ready;
  } exers_entry_t;

endpackage

// File: rtl/exers_pick.sv
// exers_pick: chooses one entry to issue from the eligibility vector.
// Default build grants the lowest-index eligible entry. With
// EXERS_OLDEST_FIRST_EN defined it also takes the age matrix
// (age[j][i] = 1 means entry j is older than entry i) and grants the
// oldest eligible entry.
module exers_pick
  import exers_pkg::*;
#(
  parameter int DEPTH = EXERS_DEPTH
) (
`ifdef EXERS_OLDEST_FIRST_EN
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
`endif
  input  logic [DEPTH-1:0]            elig,
  output logic [DEPTH-1:0]            grant
);

`ifdef EXERS_OLDEST_FIRST_EN
  logic older_found;

  // Grant an eligible entry that no other eligible entry is older than
  always_comb begin
    grant       = '0;
    older_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      older_found = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && elig[j] && age[j][i]) older_found = 1'b1;
      end
      grant[i] = elig[i] && !older_found;
    end
  end
`else
  // Isolate the lowest set bit of the eligibility vector
  assign grant = elig & (~elig + DEPTH'(1));
`endif

endmodule

// File: rtl/exers_rs.sv
// exers_rs: reservation station between rename and the scalu/mcalu pipes.
// Holds DEPTH ops, wakes waiting operands from the writeback bus, issues
// at most one ready op per cycle on a shared operand bus and drops every
// entry on a ROB flush.
// Optional macro EXERS_OLDEST_FIRST_EN: oldest-first issue via an age
// matrix; without it the lowest-index eligible entry issues.
module exers_rs
  import exers_pkg::*;
#(
  parameter int DEPTH   = EXERS_DEPTH,
  parameter int DATA_W  = EXERS_DATA_W,
  parameter int ROBID_W = EXERS_ROBID_W,
  parameter int RD_W    = EXERS_RD_W,
  parameter int OP_W    = EXERS_OP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rename_exers_write,
  input  logic [OP_W-1:0]    rename_op,
  input  logic [ROBID_W-1:0] rename_robid,
  input  logic [RD_W-1:0]    rename_rd,
  input  logic               rename_op1ready,
  input  logic [DATA_W-1:0]  rename_op1,
  input  logic               rename_op2ready,
  input  logic [DATA_W-1:0]  rename_op2,
  output logic               exers_stall,
  output logic [ROBID_W-1:0] exers_robid,
  output logic [RD_W-1:0]    exers_rd,
  output logic [DATA_W-1:0]  exers_op1,
  output logic [DATA_W-1:0]  exers_op2,
  output logic               exers_scalu0_issue,
  output logic               exers_scalu1_issue,
  output logic [OP_W-2:0]    exers_scalu_op,
  input  logic               scalu0_stall,
  input  logic               scalu1_stall,
  output logic               exers_mcalu0_issue,
  output logic               exers_mcalu1_issue,
  output logic [OP_W-2:0]    exers_mcalu_op,
  input  logic               mcalu0_stall,
  input  logic               mcalu1_stall,
  input  logic               wb_valid,
  input  logic               wb_error,
  input  logic [ROBID_W-1:0] wb_robid,
  input  logic [RD_W-1:0]    wb_rd,
  input  logic [DATA_W-1:0]  wb_result,
  input  logic               rob_flush
);

  exers_entry_t     ent [DEPTH];
  exers_entry_t     new_ent;
  exers_entry_t     sel_ent;
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] elig_vec;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] first_valid;
  logic [DEPTH-1:0] sel_oh;
  logic             wb_hit;
  logic             sc_avail;
  logic             mc_avail;
  logic             do_write;
  logic             issue_en;
  logic             sel_mc;
  logic             unused_wb_rd;

  // Tags match on robid only, so the writeback destination is not needed
  assign unused_wb_rd = ^wb_rd;

  // An erroring writeback never wakes anything; the flush that follows cleans up
  assign wb_hit   = wb_valid && !wb_error;
  assign sc_avail = !(scalu0_stall && scalu1_stall);
  assign mc_avail = !(mcalu0_stall && mcalu1_stall);

  // Per-entry valid and issue eligibility (both operands ready, class has a free unit)
  always_comb begin
    valid_vec = '0;
    elig_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent[i].valid;
      elig_vec[i]  = ent[i].valid && ent[i].op1_ready && ent[i].op2_ready &&
                     ((ent[i].op[OP_W-1] == CLASS_MCALU) ? mc_avail : sc_avail);
    end
  end

  // Stall looks only at registered valids, so an issue this cycle frees its slot next cycle
  assign exers_stall = &valid_vec;
  assign alloc_oh    = ~valid_vec & (valid_vec + DEPTH'(1));
  assign first_valid = valid_vec & (~valid_vec + DEPTH'(1));
  assign do_write    = rename_exers_write && !exers_stall && !rob_flush;

  // Build the incoming entry, capturing a same-cycle writeback so no wakeup is lost
  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.op        = rename_op;
    new_ent.robid     = rename_robid;
    new_ent.rd        = rename_rd;
    new_ent.op1       = rename_op1;
    new_ent.op1_ready = rename_op1ready;
    new_ent.op2       = rename_op2;
    new_ent.op2_ready = rename_op2ready;
    if (!rename_op1ready && wb_hit && rename_op1[ROBID_W-1:0] == wb_robid) begin
      new_ent.op1       = wb_result;
      new_ent.op1_ready = 1'b1;
    end
    if (!rename_op2ready && wb_hit && rename_op2[ROBID_W-1:0] == wb_robid) begin
      new_ent.op2       = wb_result;
      new_ent.op2_ready = 1'b1;
    end
  end

`ifdef EXERS_OLDEST_FIRST_EN
  logic [DEPTH-1:0][DEPTH-1:0] age;

  // Age matrix: a new entry is younger than every other slot; issued slots forget their history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (rob_flush) begin
      age <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_en && grant[i]) begin
          age[i] <= '0;
          for (int j = 0; j < DEPTH; j++) age[j][i] <= 1'b0;
        end
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (do_write && alloc_oh[k]) begin
          age[k] <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (j != k) age[j][k] <= 1'b1;
          end
        end
      end
    end
  end

  exers_pick #(.DEPTH(DEPTH)) u_pick (
    .age   (age),
    .elig  (elig_vec),
    .grant (grant)
  );
`else
  exers_pick #(.DEPTH(DEPTH)) u_pick (
    .elig  (elig_vec),
    .grant (grant)
  );
`endif

  // With nothing granted the bus shows the lowest valid entry, or zero when empty
  assign sel_oh = (|grant) ? grant : first_valid;

  // One-hot mux of the selected entry onto the shared operand bus
  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) sel_ent = ent[i];
    end
  end

  assign issue_en = (|grant) && !rob_flush;
  assign sel_mc   = (sel_ent.op[OP_W-1] == CLASS_MCALU);

  // Unit 0 is preferred; eligibility already guarantees unit 1 is free when unit 0 stalls
  assign exers_scalu0_issue = issue_en && !sel_mc && !scalu0_stall;
  assign exers_scalu1_issue = issue_en && !sel_mc &&  scalu0_stall;
  assign exers_mcalu0_issue = issue_en &&  sel_mc && !mcalu0_stall;
  assign exers_mcalu1_issue = issue_en &&  sel_mc &&  mcalu0_stall;

  assign exers_robid    = sel_ent.robid;
  assign exers_rd       = sel_ent.rd;
  assign exers_op1      = sel_ent.op1;
  assign exers_op2      = sel_ent.op2;
  assign exers_scalu_op = sel_ent.op[OP_W-2:0];
  assign exers_mcalu_op = sel_ent.op[OP_W-2:0];

  // Entry storage: flush beats everything, then allocate, issue and operand wakeup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (rob_flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_write && alloc_oh[i]) begin
          ent[i] <= new_ent;
        end else if (ent[i].valid) begin
          if (issue_en && grant[i]) ent[i].valid <= 1'b0;
          if (wb_hit && !ent[i].op1_ready && ent[i].op1[ROBID_W-1:0] == wb_robid) begin
            ent[i].op1       <= wb_result;
            ent[i].op1_ready <= 1'b1;
          end
          if (wb_hit && !ent[i].op2_ready && ent[i].op2[ROBID_W-1:0] == wb_robid) begin
            ent[i].op2       <= wb_result;
            ent[i].op2_ready <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_exers_rs.sv
// tb_exers_rs: directed vector bench for the exers_rs reservation station.
// A table of single-cycle vectors covers issue, wakeup, error, flush and
// routing; hand-written sequences cover fill/stall, flush with pending
// entries, picker order and asynchronous reset.
module tb_exers_rs;

  logic        clk;
  logic        rst;
  logic        rename_exers_write;
  logic [4:0]  rename_op;
  logic [7:0]  rename_robid;
  logic [5:0]  rename_rd;
  logic        rename_op1ready;
  logic [31:0] rename_op1;
  logic        rename_op2ready;
  logic [31:0] rename_op2;
  logic        exers_stall;
  logic [7:0]  exers_robid;
  logic [5:0]  exers_rd;
  logic [31:0] exers_op1;
  logic [31:0] exers_op2;
  logic        exers_scalu0_issue;
  logic        exers_scalu1_issue;
  logic [3:0]  exers_scalu_op;
  logic        scalu0_stall;
  logic        scalu1_stall;
  logic        exers_mcalu0_issue;
  logic        exers_mcalu1_issue;
  logic [3:0]  exers_mcalu_op;
  logic        mcalu0_stall;
  logic        mcalu1_stall;
  logic        wb_valid;
  logic        wb_error;
  logic [7:0]  wb_robid;
  logic [5:0]  wb_rd;
  logic [31:0] wb_result;
  logic        rob_flush;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  op;
    logic [7:0]  robid;
    logic [5:0]  rd;
    logic        r1;
    logic [31:0] op1;
    logic        r2;
    logic [31:0] op2;
    logic [3:0]  stl;
    logic        wbv;
    logic        wbe;
    logic [7:0]  wbid;
    logic [31:0] wbres;
    logic        flush;
  } in_t;

  typedef struct {
    logic        stall;
    logic [3:0]  str;
    logic        chk;
    logic [7:0]  robid;
    logic [5:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  aop;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  expc;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_order [3];

  exers_rs dut (
    .clk                (clk),
    .rst                (rst),
    .rename_exers_write (rename_exers_write),
    .rename_op          (rename_op),
    .rename_robid       (rename_robid),
    .rename_rd          (rename_rd),
    .rename_op1ready    (rename_op1ready),
    .rename_op1         (rename_op1),
    .rename_op2ready    (rename_op2ready),
    .rename_op2         (rename_op2),
    .exers_stall        (exers_stall),
    .exers_robid        (exers_robid),
    .exers_rd           (exers_rd),
    .exers_op1          (exers_op1),
    .exers_op2          (exers_op2),
    .exers_scalu0_issue (exers_scalu0_issue),
    .exers_scalu1_issue (exers_scalu1_issue),
    .exers_scalu_op     (exers_scalu_op),
    .scalu0_stall       (scalu0_stall),
    .scalu1_stall       (scalu1_stall),
    .exers_mcalu0_issue (exers_mcalu0_issue),
    .exers_mcalu1_issue (exers_mcalu1_issue),
    .exers_mcalu_op     (exers_mcalu_op),
    .mcalu0_stall       (mcalu0_stall),
    .mcalu1_stall       (mcalu1_stall),
    .wb_valid           (wb_valid),
    .wb_error           (wb_error),
    .wb_robid           (wb_robid),
    .wb_rd              (wb_rd),
    .wb_result          (wb_result),
    .rob_flush          (rob_flush)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mkIn(input logic wr, input logic [4:0] op, input logic [7:0] robid,
                               input logic [5:0] rd, input logic r1, input logic [31:0] op1,
                               input logic r2, input logic [31:0] op2, input logic [3:0] stl,
                               input logic wbv, input logic wbe, input logic [7:0] wbid,
                               input logic [31:0] wbres, input logic flush);
    in_t t;
    t.wr = wr; t.op = op; t.robid = robid; t.rd = rd;
    t.r1 = r1; t.op1 = op1; t.r2 = r2; t.op2 = op2; t.stl = stl;
    t.wbv = wbv; t.wbe = wbe; t.wbid = wbid; t.wbres = wbres; t.flush = flush;
    return t;
  endfunction

  function automatic in_t idleIn(input logic [3:0] stl);
    return mkIn(1'b0, 5'h00, 8'h00, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0, stl,
                1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
  endfunction

  function automatic in_t wbIn(input logic wbe, input logic [7:0] id, input logic [31:0] res);
    return mkIn(1'b0, 5'h00, 8'h00, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0, 4'b0000,
                1'b1, wbe, id, res, 1'b0);
  endfunction

  function automatic in_t wrIn(input logic [4:0] op, input logic [7:0] robid, input logic r1,
                               input logic [31:0] op1, input logic [3:0] stl);
    return mkIn(1'b1, op, robid, 6'h00, r1, op1, 1'b1, 32'h0, stl,
                1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
  endfunction

  function automatic out_t mkOut(input logic stall, input logic [3:0] str, input logic chk,
                                 input logic [7:0] robid, input logic [5:0] rd,
                                 input logic [31:0] op1, input logic [31:0] op2,
                                 input logic [3:0] aop);
    out_t o;
    o.stall = stall; o.str = str; o.chk = chk; o.robid = robid;
    o.rd = rd; o.op1 = op1; o.op2 = op2; o.aop = aop;
    return o;
  endfunction

  function automatic out_t outEmpty();
    return mkOut(1'b0, 4'b0000, 1'b1, 8'h00, 6'h00, 32'h0, 32'h0, 4'h0);
  endfunction

  function automatic out_t outQuiet();
    return mkOut(1'b0, 4'b0000, 1'b0, 8'h00, 6'h00, 32'h0, 32'h0, 4'h0);
  endfunction

  task automatic addVec(input string n, input in_t a, input out_t b);
    vec_t v;
    v.name = n;
    v.stim = a;
    v.expc = b;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input in_t t);
    rename_exers_write = t.wr;
    rename_op          = t.op;
    rename_robid       = t.robid;
    rename_rd          = t.rd;
    rename_op1ready    = t.r1;
    rename_op1         = t.op1;
    rename_op2ready    = t.r2;
    rename_op2         = t.op2;
    {scalu0_stall, scalu1_stall, mcalu0_stall, mcalu1_stall} = t.stl;
    wb_valid           = t.wbv;
    wb_error           = t.wbe;
    wb_robid           = t.wbid;
    wb_result          = t.wbres;
    rob_flush          = t.flush;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {exers_scalu0_issue, exers_scalu1_issue, exers_mcalu0_issue, exers_mcalu1_issue};
  endfunction

  task automatic checkOutput(input string name, input out_t e);
    checkVal({name, "_stall"}, 32'(exers_stall), 32'(e.stall));
    checkVal({name, "_strobes"}, 32'(strobes()), 32'(e.str));
    if (e.chk) begin
      checkVal({name, "_robid"}, 32'(exers_robid), 32'(e.robid));
      checkVal({name, "_rd"}, 32'(exers_rd), 32'(e.rd));
      checkVal({name, "_op1"}, exers_op1, e.op1);
      checkVal({name, "_op2"}, exers_op2, e.op2);
      checkVal({name, "_scalu_op"}, 32'(exers_scalu_op), 32'(e.aop));
      checkVal({name, "_mcalu_op"}, 32'(exers_mcalu_op), 32'(e.aop));
    end
  endtask

  initial begin
    wb_rd = 6'h00;
    applyStimulus(idleIn(4'b0000));
    rst = 1'b1;

    // Vector table: one clock per row, outputs checked before the edge
    addVec("idle0",     idleIn(4'b0000), outEmpty());
    addVec("wr_simple", mkIn(1'b1, 5'h03, 8'h04, 6'd1, 1'b1, 32'd7, 1'b1, 32'd9, 4'b0000,
                             1'b0, 1'b0, 8'h00, 32'h0, 1'b0), outEmpty());
    addVec("iss_simple", idleIn(4'b0000),
           mkOut(1'b0, 4'b1000, 1'b1, 8'h04, 6'd1, 32'd7, 32'd9, 4'h3));
    addVec("empty1",    idleIn(4'b0000), outEmpty());
    addVec("wr_wait",   mkIn(1'b1, 5'h11, 8'h05, 6'd2, 1'b0, 32'h12, 1'b1, 32'd3, 4'b0000,
                             1'b0, 1'b0, 8'h00, 32'h0, 1'b0), outEmpty());
    addVec("wait1",     idleIn(4'b0000), outQuiet());
    addVec("wb_wake",   wbIn(1'b0, 8'h12, 32'hABCD), outQuiet());
    addVec("iss_wake",  idleIn(4'b0000),
           mkOut(1'b0, 4'b0010, 1'b1, 8'h05, 6'd2, 32'hABCD, 32'd3, 4'h1));
    addVec("empty2",    idleIn(4'b0000), outEmpty());
    addVec("wr_err",    mkIn(1'b1, 5'h11, 8'h06, 6'd3, 1'b0, 32'h12, 1'b1, 32'd3, 4'b0000,
                             1'b0, 1'b0, 8'h00, 32'h0, 1'b0), outEmpty());
    addVec("err_wait",  idleIn(4'b0000), outQuiet());
    addVec("wb_err",    wbIn(1'b1, 8'h12, 32'hABCD), outQuiet());
    addVec("err_noiss1", idleIn(4'b0000), outQuiet());
    addVec("err_noiss2", idleIn(4'b0000), outQuiet());
    addVec("err_flush", mkIn(1'b0, 5'h00, 8'h00, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0, 4'b0000,
                             1'b0, 1'b0, 8'h00, 32'h0, 1'b1), outQuiet());
    addVec("empty3",    idleIn(4'b0000), outEmpty());
    addVec("wr_capture", mkIn(1'b1, 5'h02, 8'h07, 6'd4, 1'b0, 32'h20, 1'b1, 32'd1, 4'b0000,
                              1'b1, 1'b0, 8'h20, 32'h55, 1'b0), outEmpty());
    addVec("iss_capture", idleIn(4'b0000),
           mkOut(1'b0, 4'b1000, 1'b1, 8'h07, 6'd4, 32'h55, 32'd1, 4'h2));
    addVec("empty4",    idleIn(4'b0000), outEmpty());
    addVec("wr_sc1",    mkIn(1'b1, 5'h01, 8'h08, 6'd5, 1'b1, 32'd1, 1'b1, 32'd2, 4'b1000,
                             1'b0, 1'b0, 8'h00, 32'h0, 1'b0), outEmpty());
    addVec("iss_sc1",   idleIn(4'b1000),
           mkOut(1'b0, 4'b0100, 1'b1, 8'h08, 6'd5, 32'd1, 32'd2, 4'h1));
    addVec("wr_mc1",    mkIn(1'b1, 5'h14, 8'h09, 6'd6, 1'b1, 32'd3, 1'b1, 32'd4, 4'b0010,
                             1'b0, 1'b0, 8'h00, 32'h0, 1'b0), outEmpty());
    addVec("iss_mc1",   idleIn(4'b0010),
           mkOut(1'b0, 4'b0001, 1'b1, 8'h09, 6'd6, 32'd3, 32'd4, 4'h4));
    addVec("empty5",    idleIn(4'b0000), outEmpty());

`ifdef EXERS_OLDEST_FIRST_EN
    exp_order[0] = 8'hC3; exp_order[1] = 8'hC0; exp_order[2] = 8'hC1;
`else
    exp_order[0] = 8'hC0; exp_order[1] = 8'hC1; exp_order[2] = 8'hC3;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset", outEmpty());
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].stim);
      #1;
      checkOutput(vecs[k].name, vecs[k].expc);
      @(negedge clk);
    end

    // Fill all slots with both scalus stalled, then drain on scalu1
    for (int i = 0; i < 8; i++) begin
      applyStimulus(wrIn(5'h01, 8'(8'h30 + i), 1'b1, 32'(i), 4'b1100));
      #1;
      checkVal("fill_stall_low", 32'(exers_stall), 32'd0);
      @(negedge clk);
    end
    applyStimulus(wrIn(5'h01, 8'h40, 1'b1, 32'h0, 4'b1100));
    #1;
    checkVal("full_stall", 32'(exers_stall), 32'd1);
    checkVal("full_no_issue", 32'(strobes()), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(idleIn(4'b1000));
      #1;
      checkVal("drain_strobe", 32'(strobes()), 32'b0100);
      checkVal("drain_robid", 32'(exers_robid), 32'(8'h30 + i));
      checkVal("drain_stall", 32'(exers_stall), (i == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    applyStimulus(idleIn(4'b0000));
    #1;
    checkOutput("drained", outEmpty());
    @(negedge clk);

    // Flush with five eligible entries plus a same-cycle write
    for (int i = 0; i < 5; i++) begin
      applyStimulus(wrIn(5'h12, 8'(8'h60 + i), 1'b1, 32'h1, 4'b0011));
      @(negedge clk);
    end
    applyStimulus(mkIn(1'b1, 5'h02, 8'h6F, 6'h00, 1'b1, 32'h1, 1'b1, 32'h1, 4'b0000,
                       1'b0, 1'b0, 8'h00, 32'h0, 1'b1));
    #1;
    checkVal("flush_no_strobe", 32'(strobes()), 32'd0);
    @(negedge clk);
    applyStimulus(idleIn(4'b0000));
    #1;
    checkOutput("flush_empty", outEmpty());
    @(negedge clk);
    #1;
    checkOutput("flush_still_empty", outEmpty());
    @(negedge clk);

    // Picker order: slots allocated 3, 0, 1 then woken together
    applyStimulus(wrIn(5'h11, 8'hA0, 1'b1, 32'h0, 4'b0011));
    @(negedge clk);
    applyStimulus(wrIn(5'h11, 8'hA1, 1'b1, 32'h0, 4'b0011));
    @(negedge clk);
    applyStimulus(wrIn(5'h11, 8'hA2, 1'b0, 32'h51, 4'b0011));
    @(negedge clk);
    applyStimulus(wrIn(5'h05, 8'hC3, 1'b0, 32'h60, 4'b0011));
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(idleIn(4'b0001));
      #1;
      checkVal("filler_strobe", 32'(strobes()), 32'b0010);
      checkVal("filler_robid", 32'(exers_robid), 32'(8'hA0 + i));
      @(negedge clk);
    end
    applyStimulus(wrIn(5'h05, 8'hC0, 1'b0, 32'h60, 4'b0000));
    @(negedge clk);
    applyStimulus(wrIn(5'h05, 8'hC1, 1'b0, 32'h60, 4'b0000));
    @(negedge clk);
    applyStimulus(wbIn(1'b0, 8'h60, 32'h99));
    #1;
    checkVal("age_wb_no_issue", 32'(strobes()), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(idleIn(4'b0000));
      #1;
      checkVal("order_strobe", 32'(strobes()), 32'b1000);
      checkVal("order_robid", 32'(exers_robid), 32'(exp_order[i]));
      checkVal("order_op1", exers_op1, 32'h99);
      @(negedge clk);
    end
    applyStimulus(mkIn(1'b0, 5'h00, 8'h00, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0, 4'b0000,
                       1'b0, 1'b0, 8'h00, 32'h0, 1'b1));
    @(negedge clk);
    applyStimulus(idleIn(4'b0000));
    #1;
    checkOutput("age_cleared", outEmpty());

    // Asynchronous reset while an entry is about to issue
    applyStimulus(wrIn(5'h01, 8'h77, 1'b1, 32'h5, 4'b0000));
    @(negedge clk);
    applyStimulus(idleIn(4'b0000));
    #1;
    checkVal("pre_reset_issue", 32'(strobes()), 32'b1000);
    rst = 1'b1;
    #1;
    checkOutput("async_reset", outEmpty());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_reset", outEmpty());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
